// File: rtl/vga_write_arbiter_pkg.sv
// Shared VGA geometry, colour codes and arbiter state encoding.
package vga_write_arbiter_pkg;

    // VGA adapter port geometry (160x120, 3-bit colour)
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Colour codes shared by all pixel producers in the game
    typedef enum logic [COL_W-1:0] {
        BLACK   = 3'd0,
        PLAYER1 = 3'd1,
        PLAYER2 = 3'd2,
        PLAYER3 = 3'd3,
        PLAYER4 = 3'd4,
        WHITE   = 3'd7
    } colour_e;

    // Arbiter state encoding (kept as plain constants for legacy tools)
    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [STATE_W-1:0] ST_GRANT = 1'b1;

    // Width of an index into N requesters; a single requester still needs one bit
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// rr_ptr, wrapping modulo N.
module vga_write_arbiter_rr_pick
    import vga_write_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] winner,
    output logic          any_req
);

    int idx;

    // Scan from the farthest candidate back to rr_ptr so the closest one wins
    always_comb begin
        winner  = '0;
        idx     = 0;
        any_req = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port between N burst
// producers, with a per-grant burst cap and a registered pixel output stage.
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 256,
    parameter int BW        = 9
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       last,
    input  logic [X_W*N-1:0]   x_in,
    input  logic [Y_W*N-1:0]   y_in,
    input  logic [COL_W*N-1:0] colour_in,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       ack,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COL_W-1:0]   colour,
    output logic               plot,
    output logic               busy
);

    localparam int PW = ptr_width(N);
    // Count value at which the next accepted pixel forces a release
    localparam logic [BW-1:0] CAP_LAST = BW'(MAX_BURST - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [N-1:0]       gnt_q, gnt_d;

    logic [PW-1:0]      pick;
    logic               any_req;
    logic               win_req;
    logic               win_last;
    logic               release_now;
    logic               pixel_accept;

    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COL_W-1:0]   pix_col;

    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [COL_W-1:0]   colour_q;
    logic               plot_q;

    vga_write_arbiter_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick),
        .any_req (any_req)
    );

    // Handshake is a pure function of the registered grant
    assign ack          = gnt_q & req;
    assign pixel_accept = |ack;
    assign win_req      = req[win_q];
    assign win_last     = last[win_q];

    assign gnt    = gnt_q;
    assign busy   = (state_q == ST_GRANT);
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

    // Next-state: grant in IDLE, count and release in GRANT
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = gnt_q;
        release_now = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    win_d       = pick;
                    gnt_d[pick] = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (win_req) begin
                    // Cap is checked before increment, so the count never wraps
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    release_now = win_last || (burst_cnt_q == CAP_LAST);
                end else begin
                    // Requester dropped out mid-burst: abort, nothing accepted
                    release_now = 1'b1;
                end
                if (release_now) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            burst_cnt_q <= '0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
        end
    end

    // Select the granted requester's pixel from the packed input buses
    always_comb begin
        pix_x   = x_in[int'(win_q) * X_W +: X_W];
        pix_y   = y_in[int'(win_q) * Y_W +: Y_W];
        pix_col = colour_in[int'(win_q) * COL_W +: COL_W];
    end

    // VGA output stage: load on accept, otherwise hold coordinates and drop plot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= pixel_accept;
            if (pixel_accept) begin
                x_q      <= pix_x;
                y_q      <= pix_y;
                colour_q <= pix_col;
            end
        end
    end

    // Grant must never be multi-hot, and busy tracks a live grant exactly
    gnt_onehot_a: assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt_q));
    busy_gnt_a: assert property (@(posedge clk) disable iff (!resetn) busy == (gnt_q != '0));

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench: queue-driven burst producers, a transaction-level
// arbitration model checked every cycle, and directed scenarios with literal pins.
module tb_vga_write_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int BW = 3;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       l;
    } pix_t;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   last = '0;
    logic [8*N-1:0] x_in = '0;
    logic [7*N-1:0] y_in = '0;
    logic [3*N-1:0] colour_in = '0;
    logic [N-1:0]   gnt, ack;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot, busy;

    vga_write_arbiter #(
        .N         (N),
        .MAX_BURST (MB),
        .BW        (BW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .last      (last),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .gnt       (gnt),
        .ack       (ack),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    pix_t       pq[N][$];
    logic [N-1:0] ack_seen = '0;
    int         hold_pct = 0;

    int glog_who[$], glog_cyc[$];
    int plog_x[$], plog_y[$], plog_c[$], plog_cyc[$];
    logic [N-1:0] prev_gnt = '0;

    // Reference model: owner of the port (-1 idle), pixels taken, pointer, outputs
    int m_owner = -1, m_taken = 0, m_ptr = 0;
    int m_plot = 0, m_x = 0, m_y = 0, m_c = 0;
    int exp_gnt, w;
    bit found;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_taken = 0; m_ptr = 0;
        m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
    endtask

    // Asynchronous reset clears the model and the producers' pending acks
    always @(negedge resetn) begin
        model_reset();
        ack_seen = '0;
        prev_gnt = '0;
    end

    // Compare process: registered outputs and ack against the model, then advance it
    always @(negedge clk) begin
        if (resetn) begin
            exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
            chk("gnt", int'(gnt), exp_gnt);
            chk("busy", int'(busy), int'(m_owner >= 0));
            chk("gnt_onehot0", int'($onehot0(gnt)), 1);
            chk("ack", int'(ack), exp_gnt & int'(req));
            chk("plot", int'(plot), m_plot);
            chk("x", int'(x), m_x);
            chk("y", int'(y), m_y);
            chk("colour", int'(colour), m_c);

            if (gnt != '0 && prev_gnt == '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) glog_who.push_back(i);
                glog_cyc.push_back(cyc);
            end
            if (plot) begin
                plog_x.push_back(int'(x)); plog_y.push_back(int'(y));
                plog_c.push_back(int'(colour)); plog_cyc.push_back(cyc);
            end
            prev_gnt = gnt;
            ack_seen = ack;

            m_plot = 0;
            if (m_owner < 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_taken = 0;
                        found   = 1;
                    end
                end
            end else begin
                w = m_owner;
                if (req[w]) begin
                    m_plot = 1;
                    m_x = int'(x_in[8*w +: 8]);
                    m_y = int'(y_in[7*w +: 7]);
                    m_c = int'(colour_in[3*w +: 3]);
                    m_taken++;
                    if (last[w] || m_taken == MB) begin
                        m_owner = -1;
                        m_ptr   = (w + 1) % N;
                    end
                end else begin
                    m_owner = -1;
                    m_ptr   = (w + 1) % N;
                end
            end
        end
    end

    // Producers: retire acked pixels, present queue heads (random hold-offs abort bursts)
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack_seen[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() > 0 && !(hold_pct > 0 && $urandom_range(0, 99) < hold_pct)) begin
                    req[i]            = 1'b1;
                    x_in[8*i +: 8]    = pq[i][0].x;
                    y_in[7*i +: 7]    = pq[i][0].y;
                    colour_in[3*i +: 3] = pq[i][0].c;
                    last[i]           = pq[i][0].l;
                end else begin
                    req[i]  = 1'b0;
                    last[i] = 1'($urandom_range(0, 1));
                end
            end
            ack_seen = '0;
        end
    end

    task automatic push(input int r, input int px, input int py, input int pc, input bit pl);
        pix_t p;
        p.x = 8'(px); p.y = 7'(py); p.c = 3'(pc); p.l = pl;
        pq[r].push_back(p);
    endtask

    task automatic clear_logs();
        glog_who.delete(); glog_cyc.delete();
        plog_x.delete(); plog_y.delete(); plog_c.delete(); plog_cyc.delete();
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_quiet(input string nm, input int maxc);
        int q = 0;
        int n = 0;
        while (q < 2 && n <= maxc) begin
            @(negedge clk);
            n++;
            if (queues_empty() && gnt == '0 && !plot) q++;
            else q = 0;
        end
        chk({nm, "_drained"}, int'(q >= 2), 1);
    endtask

    int lc, n, total;
    int exp_x4[8] = '{100, 101, 102, 103, 50, 51, 104, 105};

    initial begin
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_busy", int'(busy), 0);

        // Single burst from requester 1
        clear_logs();
        lc = cyc + 1;
        push(1, 10, 20, 2, 0); push(1, 11, 20, 2, 0); push(1, 12, 20, 2, 1);
        wait_quiet("t1", 40);
        chk("t1_ngrants", glog_who.size(), 1);
        if (glog_who.size() > 0) begin
            chk("t1_who", glog_who[0], 1);
            chk("t1_grant_latency", glog_cyc[0] - lc, 1);
        end
        chk("t1_nplots", plog_x.size(), 3);
        for (int i = 0; i < 3 && i < plog_x.size(); i++) begin
            chk("t1_x", plog_x[i], 10 + i);
            chk("t1_y", plog_y[i], 20);
            chk("t1_c", plog_c[i], 2);
            chk("t1_plot_cycle", plog_cyc[i] - lc, 2 + i);
        end

        // Abort: requester 3 stops after one pixel without last
        clear_logs();
        push(3, 30, 40, 3, 0);
        wait_quiet("t2", 40);
        chk("t2_nplots", plog_x.size(), 1);
        chk("t2_ngrants", glog_who.size(), 1);
        // Pointer must now be 0: requesters 0 and 3 together -> 0 first
        clear_logs();
        push(0, 1, 1, 1, 1); push(3, 2, 2, 2, 1);
        wait_quiet("t2b", 40);
        chk("t2b_ngrants", glog_who.size(), 2);
        if (glog_who.size() == 2) begin
            chk("t2b_first", glog_who[0], 0);
            chk("t2b_second", glog_who[1], 3);
        end

        // Round robin, all requesting, bursts of two
        clear_logs();
        for (int r = 0; r < N; r++) begin
            for (int b = 0; b < 2; b++) begin
                push(r, 60 + r * 10 + b * 2, r, r, 0);
                push(r, 61 + r * 10 + b * 2, r, r, 1);
            end
        end
        wait_quiet("t3", 100);
        chk("t3_ngrants", glog_who.size(), 8);
        for (int i = 0; i < glog_who.size(); i++) begin
            chk("t3_order", glog_who[i], i % N);
            if (i > 0) chk("t3_spacing", glog_cyc[i] - glog_cyc[i-1], 3);
        end

        // Forced release at the burst cap
        clear_logs();
        for (int i = 0; i < 6; i++) push(0, 100 + i, 5, 4, i == 5);
        push(2, 50, 6, 1, 0); push(2, 51, 6, 1, 1);
        wait_quiet("t4", 60);
        chk("t4_ngrants", glog_who.size(), 3);
        if (glog_who.size() == 3) begin
            chk("t4_g0", glog_who[0], 0);
            chk("t4_g1", glog_who[1], 2);
            chk("t4_g2", glog_who[2], 0);
        end
        chk("t4_nplots", plog_x.size(), 8);
        for (int i = 0; i < 8 && i < plog_x.size(); i++) chk("t4_x_order", plog_x[i], exp_x4[i]);

        // Reset in the middle of requester 2's burst
        push(1, 7, 7, 7, 1);
        for (int i = 0; i < 5; i++) push(2, 80 + i, 9, 5, i == 4);
        n = 0;
        while (gnt != 4'b0100 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_r2_granted", int'(gnt), 4);
        @(negedge clk);
        chk("t5_plot_before", int'(plot), 1);
        #2 resetn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) pq[i].delete();
        chk("t5_gnt", int'(gnt), 0);
        chk("t5_plot", int'(plot), 0);
        chk("t5_x", int'(x), 0);
        chk("t5_y", int'(y), 0);
        chk("t5_colour", int'(colour), 0);
        @(posedge clk);
        @(posedge clk);
        #3 resetn = 1'b1;
        @(negedge clk);
        // Pointer is back at 0: requesters 1 and 3 together -> 1 first
        clear_logs();
        push(1, 8, 8, 5, 1); push(3, 9, 11, 6, 1);
        wait_quiet("t5b", 40);
        chk("t5b_ngrants", glog_who.size(), 2);
        if (glog_who.size() == 2) begin
            chk("t5b_first", glog_who[0], 1);
            chk("t5b_second", glog_who[1], 3);
        end

        // Idle hold: outputs keep the last plotted pixel
        clear_logs();
        repeat (50) @(negedge clk);
        chk("t6_nplots", plog_x.size(), 0);
        chk("t6_x", int'(x), 9);
        chk("t6_y", int'(y), 11);
        chk("t6_colour", int'(colour), 6);

        // Randomized bursts with hold-offs that cause aborts
        clear_logs();
        total = 0;
        hold_pct = 15;
        for (int r = 0; r < N; r++) begin
            for (int b = 0; b < int'($urandom_range(2, 5)); b++) begin
                n = int'($urandom_range(1, 7));
                for (int i = 0; i < n; i++) begin
                    push(r, int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
                         int'($urandom_range(0, 7)), i == n - 1);
                    total++;
                end
            end
        end
        wait_quiet("rand", 3000);
        hold_pct = 0;
        chk("rand_nplots", plog_x.size(), total);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) between N pixel producers: the sprite/tank draw engine, the map painter, a score overlay and an explosion effect.
- Each producer streams pixels in bursts over a req/ack handshake.
- The arbiter grants one producer per burst, in round-robin order, and registers the winning pixel onto the VGA port.
- A burst-length cap stops one producer, such as a full-screen map fill, from starving the others.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_BURST, 256, maximum pixels accepted per grant before forced release (1..511).
- BW, 9, burst counter width; must satisfy 2^BW > MAX_BURST.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  N  per-requester pixel valid; the pixel on the requester's slice is valid while high.
- last  in  N  per-requester flag marking the current pixel as the final pixel of the burst.
- x_in  in  8*N  packed x coordinates; requester i occupies bits [8i+7:8i].
- y_in  in  7*N  packed y coordinates; requester i occupies bits [7i+6:7i].
- colour_in  in  3*N  packed colours; requester i occupies bits [3i+2:3i].
- gnt  out  N  one-hot grant (all zero when idle).
- ack  out  N  pixel accepted this cycle; equals gnt & req (combinational from the registered gnt).
- x  out  8  VGA x, registered.
- y  out  7  VGA y, registered.
- colour  out  3  VGA colour, registered.
- plot  out  1  VGA write enable, registered.
- busy  out  1  high while in state GRANT.

Behaviour:
- Reset (resetn low, asynchronous):
  - Outputs: gnt=0, x=0, y=0, colour=0, plot=0.
  - Internal: state=IDLE, rr_ptr=0, burst_cnt=0.
- State machine, two states:
  - IDLE:
    - If req != 0, pick the winner as the first set bit of req searching upward from rr_ptr, wrapping modulo N.
    - Register gnt=onehot(winner), clear burst_cnt, go to GRANT.
    - If req == 0, stay in IDLE with gnt=0.
  - GRANT:
    - ack[w] = req[w] in each cycle, where w is the granted index.
    - On each ack, burst_cnt increments.
    - A requester presents its next pixel in the cycle after its ack.
- Release: from GRANT, go to IDLE on the clock edge after the first of these:
  - (a) ack with last[w]=1;
  - (b) req[w]=0 (abort, no pixel accepted);
  - (c) ack while burst_cnt == MAX_BURST-1 (forced release; the requester keeps req high and resumes later).
- On release:
  - gnt clears at the same edge.
  - rr_ptr = (w+1) mod N.
- Arbitration cost: every grant costs exactly one IDLE cycle. Peak throughput is therefore one pixel per cycle within a burst.
- Output pipeline:
  - When ack[w]=1, x/y/colour/plot are loaded with the slice-w pixel and plot=1 on the next edge.
  - Otherwise plot=0 and x/y/colour hold their previous values.
  - Latency from ack to plot is one cycle.
- Boundary conditions:
  - Simultaneous requests: only one requester is granted.
  - Release coinciding with new requests: the next arbitration still happens in the IDLE cycle. No back-to-back grants.
  - last asserted with req low: ignored; this is an abort.
  - gnt is never all-ones or multi-hot; verify with an assertion.
  - Reset mid-burst: immediate return to reset values; the partially-drawn burst is lost. The producer must restart on its own reset.
  - MAX_BURST=1: every pixel is its own grant.
- Width rules:
  - burst_cnt is BW bits and never wraps; forced release occurs first.
  - rr_ptr is ceil(log2 N) bits, wrapping modulo N (not modulo 2^width).

Decomposition:
- Shared package holds VGA geometry and colour constants used across the game:
  - X_W=8, Y_W=7, COL_W=3, SCREEN_W=160, SCREEN_H=120.
  - Colour codes: BLACK=0, PLAYER1..PLAYER4=1..4, WHITE=7.
  - State encoding for IDLE and GRANT.
- One natural sub-module: rr_pick. It is a combinational round-robin priority encoder with inputs req[N-1:0] and rr_ptr, and outputs winner index and any_req.

Test Plan:
- Single burst: requester 1 sends 3 pixels, (10,20,c=2), (11,20,2), (12,20,2) with last on the third, req held high → gnt=0010 after one IDLE cycle; plot high for 3 consecutive cycles with matching x/y/colour, each one cycle after its ack; busy then drops.
- Round-robin: req=1111 continuously, each burst length 2 → grant order 0,1,2,3,0; each grant is separated by exactly one cycle with gnt=0.
- Forced release: MAX_BURST=4; requester 0 bursts 6 pixels while requester 2 waits → 4 pixels plotted from requester 0; requester 2 is granted next; requester 0's remaining 2 pixels are plotted on its following grant.
- Abort: requester 3 granted, drops req after 1 ack without last → return to IDLE; rr_ptr=0; exactly 1 plot pulse.
- Reset mid-burst: assert resetn low asynchronously between clock edges during GRANT → gnt, plot, x, y and colour go to 0 immediately; after release with req=0100, grant goes to requester 2 (rr_ptr=0 search).
- Idle hold: req=0 for 50 cycles → plot stays 0 and x/y/colour keep their last values.
